mesh: RTL and testbench
=======================

MESH -- requirements
Module: mesh

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the node count; N SHALL be a perfect square, with side S = sqrt(N) = 4.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the sort key.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, giving the node address width, equal to log2(N).
REQ-004 The block SHALL have parameter WIDTH, default ADDR_WIDTH+DATA_WIDTH, giving the width of a message.
REQ-005 The block SHALL have parameter SORT_CYCLES, default 21, giving the number of clock edges from reset release to sort completion.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have no other ports, except as stated in REQ-023.
REQ-009 Each node k (0..N-1) SHALL expose a register nanci_result[WIDTH:0] at hierarchy GEN[k].GENIF.PE.app_init.nanci_result.
- Layout: bit WIDTH = busy; next ADDR_WIDTH bits = own address k; low DATA_WIDTH bits = key.

Function
REQ-010 Nodes SHALL form an SxS mesh in snake order.
- Node k sits at row r = k/S.
- Column c = k%S when r is even, S-1-k%S when r is odd.
REQ-011 The initial key of node k SHALL be k.
REQ-012 The mesh SHALL sort keys descending along snake order, so that node k finally holds N-1-k.
REQ-013 Sorting SHALL use shear sort in five phases: row, column, row, column, row.
- Each phase is 4 odd-even transposition steps: even steps exchange pairs (0,1),(2,3); odd steps exchange pair (1,2).
- One step completes per clock cycle, 20 steps total.
REQ-014 Row compare-exchange direction SHALL be:
- Even rows: larger key to the lower column.
- Odd rows: larger key to the higher column.
REQ-015 Column compare-exchange SHALL place the larger key at the lower row.
REQ-016 Equal keys SHALL NOT be swapped.
REQ-017 A step counter SHALL sequence the sort.
- Counter resets to 0.
- On each rising edge with count < 20: perform step count, then increment.
- On the edge with count = 20: clear busy in all nodes and set count = SORT_CYCLES.
- Counter saturates at SORT_CYCLES.
REQ-018 After busy clears, all nanci_result values SHALL hold constant until the next reset.
REQ-019 The address field of each node SHALL always equal k; only the key field moves.

Reset
REQ-020 While rst is low, every node SHALL hold {1'b1, k, k}, the step counter SHALL be 0, and any optional done output SHALL be 0.
REQ-021 Reset asserted mid-sort SHALL abort the sort immediately, with no partial state retained.
REQ-022 After reset release, the sort SHALL restart from step 0.

Configuration
REQ-023 When macro MESH_DONE_PORT_EN is defined, the block SHALL add output port done (1 bit).
- done is 0 from reset until the edge that clears busy, then 1.
- When the macro is undefined, the port is absent; the sort behaves identically in both cases.

Verification
REQ-024 Hold rst low for 2 cycles -> every node k reads {1, k, k}, e.g. node 3 = {1,3,3}.
REQ-025 Release rst and wait 21 edges -> node k = {0, k, 15-k}; node 0 = {0,0,15}, node 15 = {0,15,0}; all 16 checks pass simultaneously.
REQ-026 Check after edge 20 versus edge 21 -> busy = 1 in all nodes after edge 20 and 0 after edge 21.
REQ-027 Assert rst after edge 10, hold 1 cycle, release -> nodes revert to {1,k,k} immediately; sorted result appears 21 edges after the second release.
REQ-028 Run 200 cycles after completion -> no nanci_result bit changes.
REQ-029 With MESH_DONE_PORT_EN defined -> done = 0 through edge 20 and 1 from edge 21 onward; without the macro -> the bench compiles with no done port.

Source files
------------

// File: rtl/mesh.sv
// 4x4 (generally SxS) snake-order mesh that shear-sorts node keys descending.
// Each node k starts with key k and ends holding N-1-k; the address field never
// moves. Five phases (row, column, row, column, row) of S odd-even transposition
// steps run one step per clock. Optional macro MESH_DONE_PORT_EN adds a 'done'
// output that rises on the edge that clears busy.

// Per-node message register: {busy, own address, key}.
module mesh_app_init #(
    parameter int K          = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_en,
    input  logic                  finish,
    input  logic [DATA_WIDTH-1:0] key_next,
    output logic [DATA_WIDTH-1:0] key
);
    logic [WIDTH:0] nanci_result;

    // Load the key on sort steps, drop busy at completion; address is rewritten with itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nanci_result <= {1'b1, ADDR_WIDTH'(K), DATA_WIDTH'(K)};
        end else if (step_en || finish) begin
            nanci_result <= {nanci_result[WIDTH] & ~finish,
                             nanci_result[WIDTH-1:DATA_WIDTH],
                             step_en ? key_next : nanci_result[DATA_WIDTH-1:0]};
        end
    end

    assign key = nanci_result[DATA_WIDTH-1:0];
endmodule

// Processing element: compare-exchange against the partner chosen by the mesh.
module mesh_pe #(
    parameter int K          = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_en,
    input  logic                  finish,
    input  logic                  has_partner,
    input  logic                  take_larger,
    input  logic [DATA_WIDTH-1:0] partner_key,
    output logic [DATA_WIDTH-1:0] key
);
    logic [DATA_WIDTH-1:0] key_next;

    // Keep the larger or smaller of the pair; strict compares leave equal keys alone.
    always_comb begin
        key_next = key;
        if (has_partner) begin
            if (take_larger && (partner_key > key)) begin
                key_next = partner_key;
            end else if (!take_larger && (partner_key < key)) begin
                key_next = partner_key;
            end
        end
    end

    mesh_app_init #(
        .K(K), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)
    ) app_init (
        .clk(clk), .rst(rst), .step_en(step_en), .finish(finish),
        .key_next(key_next), .key(key)
    );
endmodule

module mesh #(
    parameter int N           = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int WIDTH       = ADDR_WIDTH + DATA_WIDTH,
    parameter int SORT_CYCLES = 21
) (
    input  logic clk,
    input  logic rst
`ifdef MESH_DONE_PORT_EN
    ,
    output logic done
`endif
);
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    localparam int S     = isqrt(N);
    localparam int STEPS = 5 * S;
    localparam int CW    = $clog2(SORT_CYCLES + 1);

    // Grid column of node k under snake ordering.
    function automatic int col_of(input int k);
        return (((k / S) % 2) == 0) ? (k % S) : (S - 1 - (k % S));
    endfunction

    // Node index sitting at grid (r, c).
    function automatic int node_of(input int r, input int c);
        return ((r % 2) == 0) ? (r * S + c) : (r * S + S - 1 - c);
    endfunction

    // Partner position in an odd-even transposition step, -1 when idle.
    function automatic int partner_pos(input int pos, input int odd);
        int p;
        p = -1;
        if (odd == 0) p = pos ^ 1;
        else if ((pos % 2) == 1) p = pos + 1;
        else if (pos > 0) p = pos - 1;
        if (p >= S) p = -1;
        return p;
    endfunction

    logic [CW-1:0]         count_reg;
    logic                  step_en;
    logic                  finish;
    logic                  row_phase;
    logic                  odd_step;
    int                    phase_idx;
    int                    step_idx;
    logic [DATA_WIDTH-1:0] node_key [N];

    // Decode the step counter into phase type and step parity.
    always_comb begin
        phase_idx = int'(count_reg) / S;
        step_idx  = int'(count_reg) % S;
        step_en   = count_reg < CW'(STEPS);
        finish    = count_reg == CW'(STEPS);
        row_phase = (phase_idx % 2) == 0;
        odd_step  = (step_idx % 2) == 1;
    end

    // Step counter: advance through the sort, then park at SORT_CYCLES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (step_en) begin
            count_reg <= count_reg + 1'b1;
        end else if (finish) begin
            count_reg <= CW'(SORT_CYCLES);
        end
    end

`ifdef MESH_DONE_PORT_EN
    assign done = count_reg == CW'(SORT_CYCLES);
`endif

    for (genvar gi = 0; gi < N; gi++) begin : GEN
        if (1) begin : GENIF
            localparam int R    = gi / S;
            localparam int C    = col_of(gi);
            localparam int P_RE = partner_pos(C, 0);
            localparam int P_RO = partner_pos(C, 1);
            localparam int P_CE = partner_pos(R, 0);
            localparam int P_CO = partner_pos(R, 1);
            localparam int N_RE = (P_RE < 0) ? gi : node_of(R, P_RE);
            localparam int N_RO = (P_RO < 0) ? gi : node_of(R, P_RO);
            localparam int N_CE = (P_CE < 0) ? gi : node_of(P_CE, C);
            localparam int N_CO = (P_CO < 0) ? gi : node_of(P_CO, C);

            logic                  has_partner;
            logic                  take_larger;
            logic [DATA_WIDTH-1:0] partner_key;

            // Pick this step's partner; even rows and all columns pull the larger key
            // toward the lower index, odd rows push it toward the higher column.
            always_comb begin
                has_partner = 1'b0;
                take_larger = 1'b0;
                partner_key = node_key[gi];
                if (row_phase) begin
                    if (odd_step) begin
                        has_partner = P_RO >= 0;
                        partner_key = node_key[N_RO];
                        take_larger = (C < P_RO) == ((R % 2) == 0);
                    end else begin
                        has_partner = P_RE >= 0;
                        partner_key = node_key[N_RE];
                        take_larger = (C < P_RE) == ((R % 2) == 0);
                    end
                end else begin
                    if (odd_step) begin
                        has_partner = P_CO >= 0;
                        partner_key = node_key[N_CO];
                        take_larger = R < P_CO;
                    end else begin
                        has_partner = P_CE >= 0;
                        partner_key = node_key[N_CE];
                        take_larger = R < P_CE;
                    end
                end
            end

            mesh_pe #(
                .K(gi), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)
            ) PE (
                .clk(clk), .rst(rst), .step_en(step_en), .finish(finish),
                .has_partner(has_partner), .take_larger(take_larger),
                .partner_key(partner_key), .key(node_key[gi])
            );
        end
    end
endmodule

// File: tb/tb_mesh.sv
// Directed bench for mesh: reset values, first-step pattern, final sorted
// values, busy timing, post-completion stability and mid-sort abort/restart.
module tb_mesh;
    localparam int N  = 16;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int W  = AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef MESH_DONE_PORT_EN
    logic done;
`endif

    int checks = 0;
    int errors = 0;

    mesh #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WIDTH(W), .SORT_CYCLES(21)) dut (
        .clk(clk),
        .rst(rst)
`ifdef MESH_DONE_PORT_EN
        ,
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    logic [W:0] obs [N];
    for (genvar gi = 0; gi < N; gi++) begin : TAP
        assign obs[gi] = dut.GEN[gi].GENIF.PE.app_init.nanci_result;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] word_of(input logic b, input int k, input int key);
        return {b, AW'(k), DW'(key)};
    endfunction

    // mode 0: key = k, mode 1: key = k^1 (after first step), mode 2: key = N-1-k
    task automatic check_nodes(input string tag, input logic b, input int mode);
        int key;
        for (int k = 0; k < N; k++) begin
            key = (mode == 0) ? k : (mode == 1) ? (k ^ 1) : (N - 1 - k);
            check($sformatf("%s[%0d]", tag, k), 64'(obs[k]), 64'(word_of(b, k, key)));
        end
    endtask

    task automatic check_done(input string tag, input logic exp);
`ifdef MESH_DONE_PORT_EN
        check($sformatf("%s_done", tag), 64'(done), 64'(exp));
`endif
    endtask

    // Called just after rst rises: walk 21 edges and check the key points.
    task automatic run_sort(input string tag);
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk);
            #1;
            if (e == 1)  check_nodes($sformatf("%s_e1", tag), 1'b1, 1);
            if (e == 20) check_nodes($sformatf("%s_e20", tag), 1'b1, 2);
            if (e == 21) check_nodes($sformatf("%s_e21", tag), 1'b0, 2);
            check_done($sformatf("%s_e%0d", tag, e), e >= 21);
            $display("[%s] edge %0d node0=0x%0h node15=0x%0h", tag, e, obs[0], obs[N-1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two cycles
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_nodes("reset", 1'b1, 0);
        check_done("reset", 1'b0);
        $display("[reset] node3=0x%0h", obs[3]);

        // Full sort
        @(negedge clk);
        rst = 1'b1;
        run_sort("sort1");

        // Stability after completion
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            check_nodes("hold", 1'b0, 2);
            check_done("hold", 1'b1);
        end
        $display("[hold] 200 cycles observed");

        // Clean restart, then abort after edge 10
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_nodes("abort", 1'b1, 0);
        check_done("abort", 1'b0);
        @(posedge clk);
        #1;
        check_nodes("abort_hold", 1'b1, 0);
        @(negedge clk);
        rst = 1'b1;
        $display("[abort] reset pulse applied after edge 10");
        run_sort("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
